// File: rtl/drap_shiftr_seq_if.sv
// Start/done handshake bundle between the control unit and the multi-cycle right shifter.
interface drap_shiftr_seq_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
);
  logic             start;
  logic             arith;
  logic [WIDTH-1:0] din;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;

  modport master (
    output start, arith, din, shamt,
    input  busy, done, dout
  );

  modport slave (
    input  start, arith, din, shamt,
    output busy, done, dout
  );
endinterface

// File: rtl/drap_shiftr_seq.sv
// Multi-cycle SRL/SRA: shifts a latched operand right one bit per clock,
// pulsing done with the result after shamt+1 cycles.
module drap_shiftr_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input logic               clk,
  input logic               rst_n,
  drap_shiftr_seq_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             fill_c;

  // Sign fill comes from the current MSB, which every step preserves in SRA mode
  assign fill_c = mode_q & sreg_q[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state and next-output logic; done defaults low so it lasts one cycle
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sreg_d  = bus.din;
          cnt_d   = bus.shamt;
          mode_d  = bus.arith;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          sreg_d = {fill_c, sreg_q[WIDTH-1:1]};
          cnt_d  = cnt_q - SHW'(1);
        end else begin
          dout_d  = sreg_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = dout_q;

endmodule
